// File: rtl/reg_cdc_req_sched.sv
// Purpose: round-robin scheduler sharing one register-CDC request channel among NumReq requesters.
// Latency: gnt_o is combinational in StIdle; cdc_req_o rises the next cycle; the response pulses one cycle after cdc_ack_i.
// Backpressure: one command in flight; requesters hold req_i until gnt_o; a timed-out command stays on the channel until its stale ack drains.
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   req_i/we_i/addr_i/wdata_i            per-requester level request and command (packed, requester i at slice i)
//   gnt_o, rsp_valid_o                   one-hot single-cycle grant / response pulses
//   rsp_err_o, rsp_rdata_o               response status and read data, zero outside response cycles
//   cdc_req_o/we_o/addr_o/wdata_o        held command towards the CDC; cdc_ack_i/cdc_rdata_i come back
//   busy_o, spurious_ack_o               not idle; sticky flag for an ack seen with no request outstanding
module reg_cdc_req_sched #(
  parameter int NumReq        = 4,
  parameter int AddrWidth     = 8,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic                          rsp_err_o,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output logic                          cdc_req_o,
  output logic                          cdc_we_o,
  output logic [AddrWidth-1:0]          cdc_addr_o,
  output logic [DataWidth-1:0]          cdc_wdata_o,
  input  logic                          cdc_ack_i,
  input  logic [DataWidth-1:0]          cdc_rdata_i,
  output logic                          busy_o,
  output logic                          spurious_ack_o
);

  localparam int PtrW = $clog2(NumReq);
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit TimeoutEn = (TimeoutCycles > 0);
  localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NumReq - 1);
  localparam logic [PtrW:0]   NumReqS = (PtrW + 1)'(NumReq);

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PtrW-1:0]       id_q, id_d;
  logic                  we_q, we_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic                  cdc_req_q, cdc_req_d;
  logic [NumReq-1:0]     rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DataWidth-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                  spurious_q, spurious_d;

  logic                  arb_any;
  logic [PtrW-1:0]       arb_idx;
  logic [PtrW:0]         cand;
  logic                  sel_we;
  logic [AddrWidth-1:0]  sel_addr;
  logic [DataWidth-1:0]  sel_wdata;
  logic                  rsp_fire;

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    arb_any = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, ptr_q} + (PtrW + 1)'(k);
      if (cand >= NumReqS) cand = cand - NumReqS;
      if (!arb_any && req_i[cand[PtrW-1:0]]) begin
        arb_any = 1'b1;
        arb_idx = cand[PtrW-1:0];
      end
    end
  end

  // Command mux for the winner, and the grant pulse. The grant is masked
  // during reset so every output reads zero while rst_ni is low.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    gnt_o     = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (arb_idx == PtrW'(i)) begin
        sel_we    = we_i[i];
        sel_addr  = addr_i[i*AddrWidth +: AddrWidth];
        sel_wdata = wdata_i[i*DataWidth +: DataWidth];
        gnt_o[i]  = rst_ni && (state_q == StIdle) && arb_any;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cdc_req_d   = cdc_req_q;
    rsp_fire    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    // Any ack while no request is on the channel is a protocol error upstream.
    spurious_d  = spurious_q | (cdc_ack_i & ~cdc_req_q);
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          id_d      = arb_idx;
          we_d      = sel_we;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          ptr_d     = (arb_idx == PtrLast) ? '0 : arb_idx + 1'b1;
          cnt_d     = '0;
          cdc_req_d = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (cdc_ack_i) begin
          cdc_req_d   = 1'b0;
          rsp_fire    = 1'b1;
          rsp_rdata_d = cdc_rdata_i;
          state_d     = StIdle;
        end else if (TimeoutEn && cnt_q == CntLast) begin
          // Error back to the requester now; the command stays on the
          // channel so the late ack can still complete the handshake.
          rsp_fire  = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = StDrain;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cdc_ack_i) begin
          cdc_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (id_q == PtrW'(i)) rsp_valid_d[i] = rsp_fire;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cdc_req_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cdc_req_q   <= cdc_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      spurious_q  <= spurious_d;
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_err_o      = rsp_err_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign cdc_req_o      = cdc_req_q;
  assign cdc_we_o       = we_q;
  assign cdc_addr_o     = addr_q;
  assign cdc_wdata_o    = wdata_q;
  assign busy_o         = (state_q != StIdle);
  assign spurious_ack_o = spurious_q;

endmodule

// File: tb/tb_reg_cdc_req_sched.sv
// Purpose: self-checking bench for reg_cdc_req_sched (directed scenarios plus randomized traffic).
// Latency: inputs driven 1 time unit after posedge; model compares at every negedge.
// Backpressure: requesters hold their command until granted, then release or re-request at random.
module tb_reg_cdc_req_sched;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_v, we_v;
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_wdata [N];
  logic [N*AW-1:0] addr_p;
  logic [N*DW-1:0] wdata_p;
  logic [N-1:0]  gnt, rsp_valid;
  logic          rsp_err, cdc_req, cdc_we, cdc_ack, busy, spur;
  logic [DW-1:0] rsp_rdata, cdc_wdata, cdc_rdata;
  logic [AW-1:0] cdc_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    addr_p  = '0;
    wdata_p = '0;
    for (int i = 0; i < N; i++) begin
      addr_p[i*AW +: AW]  = r_addr[i];
      wdata_p[i*DW +: DW] = r_wdata[i];
    end
  end

  reg_cdc_req_sched #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req_v), .we_i(we_v), .addr_i(addr_p), .wdata_i(wdata_p),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
    .cdc_req_o(cdc_req), .cdc_we_o(cdc_we), .cdc_addr_o(cdc_addr), .cdc_wdata_o(cdc_wdata),
    .cdc_ack_i(cdc_ack), .cdc_rdata_i(cdc_rdata),
    .busy_o(busy), .spurious_ack_o(spur)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Transaction-level reference: absolute cycle numbers decide when a
  // command was granted, when it times out and when its response is due.
  int            m_cyc, m_g, m_id, m_ptr, m_pid, m_sel, m_j;
  bit            m_act, m_stale, m_pend, m_perr, m_spur;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_pdata;
  logic [N-1:0]  m_tmp, e_gnt, e_rv;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_rsp_err", 64'(rsp_err), 64'h0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
      chk("rst_cdc_req", 64'(cdc_req), 64'h0);
      chk("rst_cdc_we", 64'(cdc_we), 64'h0);
      chk("rst_cdc_addr", 64'(cdc_addr), 64'h0);
      chk("rst_cdc_wdata", 64'(cdc_wdata), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_spurious", 64'(spur), 64'h0);
      m_act = 0; m_stale = 0; m_pend = 0; m_spur = 0; m_ptr = 0; m_cyc = 0;
    end else begin
      m_sel = -1;
      if (!m_act) begin
        for (int k = 0; k < N; k++) begin
          m_j   = (m_ptr + k) % N;
          m_tmp = req_v >> m_j;
          if (m_sel < 0 && m_tmp[0]) m_sel = m_j;
        end
      end
      e_gnt = (m_sel >= 0) ? (N'(1) << m_sel) : '0;
      e_rv  = m_pend ? (N'(1) << m_pid) : '0;
      chk("gnt", 64'(gnt), 64'(e_gnt));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("rsp_err", 64'(rsp_err), 64'(m_pend & m_perr));
      chk("rsp_rdata", 64'(rsp_rdata), m_pend ? 64'(m_pdata) : 64'h0);
      chk("cdc_req", 64'(cdc_req), 64'(m_act));
      chk("busy", 64'(busy), 64'(m_act));
      chk("spurious", 64'(spur), 64'(m_spur));
      if (m_act) begin
        chk("cdc_we", 64'(cdc_we), 64'(m_we));
        chk("cdc_addr", 64'(cdc_addr), 64'(m_addr));
        chk("cdc_wdata", 64'(cdc_wdata), 64'(m_wdata));
      end
      m_pend = 0;
      if (cdc_ack && !m_act) m_spur = 1;
      if (m_act) begin
        if (cdc_ack) begin
          m_act = 0;
          if (!m_stale) begin
            m_pend = 1; m_perr = 0; m_pdata = cdc_rdata; m_pid = m_id;
          end
        end else if (!m_stale && (m_cyc - m_g) == TO) begin
          m_stale = 1; m_pend = 1; m_perr = 1; m_pdata = '0; m_pid = m_id;
        end
      end else if (m_sel >= 0) begin
        m_act = 1; m_stale = 0; m_g = m_cyc; m_id = m_sel;
        m_we = we_v[m_sel]; m_addr = r_addr[m_sel]; m_wdata = r_wdata[m_sel];
        m_ptr = (m_sel + 1) % N;
      end
      m_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_v = '0; cdc_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  bit           pend [N];
  logic [N-1:0] last_gnt;

  initial begin
    rst_n = 1'b0; req_v = '0; we_v = '0; cdc_ack = 1'b0; cdc_rdata = '0;
    for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_wdata[i] = '0; pend[i] = 0; end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("d_reset_busy", 64'(busy), 64'h0);
    chk("d_reset_spur", 64'(spur), 64'h0);

    // Round robin with all four requesting and immediate acks.
    for (int i = 0; i < N; i++) begin r_addr[i] = AW'(8'h40 + i); r_wdata[i] = $urandom; end
    we_v = 4'b0101; req_v = 4'hF;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("d_rr_gnt", 64'(gnt), 64'(N'(1) << (i % N)));
      if (i > 0) chk("d_rr_rsp", 64'(rsp_valid), 64'(N'(1) << ((i - 1) % N)));
      tick();
      cdc_ack = 1'b1; cdc_rdata = $urandom;
      #1;
      chk("d_rr_busy_gnt", 64'(gnt), 64'h0);
      tick();
      cdc_ack = 1'b0;
      if (i == 4) req_v = '0;
      #1;
    end
    chk("d_rr_last_rsp", 64'(rsp_valid), 64'h1);

    // Single read from requester 2, ack three cycles after cdc_req_o rises.
    do_reset();
    r_addr[2] = 8'h14; we_v = '0; req_v = 4'b0100;
    #1;
    chk("d_rd_gnt", 64'(gnt), 64'h4);
    tick(); req_v = '0; #1;
    chk("d_rd_cdc_req", 64'(cdc_req), 64'h1);
    chk("d_rd_addr", 64'(cdc_addr), 64'h14);
    ticks(3);
    cdc_ack = 1'b1; cdc_rdata = 32'hDEADBEEF; #1;
    chk("d_rd_addr_held", 64'(cdc_addr), 64'h14);
    tick(); cdc_ack = 1'b0; cdc_rdata = $urandom; #1;
    chk("d_rd_rsp", 64'(rsp_valid), 64'h4);
    chk("d_rd_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("d_rd_err", 64'(rsp_err), 64'h0);
    chk("d_rd_req_fall", 64'(cdc_req), 64'h0);
    tick();
    chk("d_rd_rsp_once", 64'(rsp_valid), 64'h0);

    // Timeout, error response, then the stale ack drains silently.
    do_reset();
    r_addr[1] = 8'h33; r_wdata[1] = 32'hA5A5_0001; we_v = 4'b0010; req_v = 4'b0010;
    #1;
    chk("d_to_gnt", 64'(gnt), 64'h2);
    tick(); req_v = '0;
    ticks(7);
    chk("d_to_early", 64'(rsp_valid), 64'h0);
    tick();
    chk("d_to_rsp", 64'(rsp_valid), 64'h2);
    chk("d_to_err", 64'(rsp_err), 64'h1);
    chk("d_to_rdata", 64'(rsp_rdata), 64'h0);
    chk("d_to_req_held", 64'(cdc_req), 64'h1);
    ticks(5);
    cdc_ack = 1'b1; cdc_rdata = 32'hFFFF_FFFF;
    tick(); cdc_ack = 1'b0;
    req_v = 4'b0001; r_addr[0] = 8'h07; we_v = '0;
    #1;
    chk("d_to_drain_norsp", 64'(rsp_valid), 64'h0);
    chk("d_to_drain_idle", 64'(busy), 64'h0);
    chk("d_to_new_gnt", 64'(gnt), 64'h1);
    tick(); req_v = '0; cdc_ack = 1'b1; cdc_rdata = 32'h0000_1234;
    tick(); cdc_ack = 1'b0; #1;
    chk("d_to_new_rsp", 64'(rsp_valid), 64'h1);
    chk("d_to_new_err", 64'(rsp_err), 64'h0);

    // Ack coincident with the last timeout cycle: normal response.
    req_v = 4'b1000; r_addr[3] = 8'hC3; #1;
    chk("d_co_gnt", 64'(gnt), 64'h8);
    tick(); req_v = '0;
    ticks(7);
    cdc_ack = 1'b1; cdc_rdata = 32'h1234_5678;
    tick(); cdc_ack = 1'b0; #1;
    chk("d_co_rsp", 64'(rsp_valid), 64'h8);
    chk("d_co_err", 64'(rsp_err), 64'h0);
    chk("d_co_rdata", 64'(rsp_rdata), 64'h1234_5678);
    chk("d_co_idle", 64'(busy), 64'h0);

    // Spurious ack in idle.
    tick(); cdc_ack = 1'b1; #1;
    chk("d_sp_before", 64'(spur), 64'h0);
    tick(); cdc_ack = 1'b0; #1;
    chk("d_sp_set", 64'(spur), 64'h1);
    chk("d_sp_norsp", 64'(rsp_valid), 64'h0);
    req_v = 4'b0001; tick(); req_v = '0; cdc_ack = 1'b1; cdc_rdata = 32'h0BAD_F00D;
    tick(); cdc_ack = 1'b0; #1;
    chk("d_sp_txn_rsp", 64'(rsp_valid), 64'h1);
    chk("d_sp_txn_rdata", 64'(rsp_rdata), 64'h0BAD_F00D);
    chk("d_sp_sticky", 64'(spur), 64'h1);

    // Reset asserted in the middle of StWait.
    tick(); req_v = 4'b0010; tick(); req_v = '0; tick();
    rst_n = 1'b0; req_v = 4'hF; #1;
    chk("d_mr_gnt", 64'(gnt), 64'h0);
    chk("d_mr_cdc_req", 64'(cdc_req), 64'h0);
    chk("d_mr_busy", 64'(busy), 64'h0);
    chk("d_mr_spur", 64'(spur), 64'h0);
    tick(); tick();
    rst_n = 1'b1; req_v = 4'b1000; #1;
    chk("d_mr_gnt3", 64'(gnt), 64'h8);
    tick(); req_v = '0; cdc_ack = 1'b1; cdc_rdata = 32'h0000_0033;
    tick(); cdc_ack = 1'b0; #1;
    chk("d_mr_rsp3", 64'(rsp_valid), 64'h8);

    // Randomized traffic; the negedge model checks every cycle.
    last_gnt = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (last_gnt[i]) begin
          if ($urandom_range(1, 0) == 0) pend[i] = 0;
          else begin
            we_v[i] = 1'($urandom); r_addr[i] = AW'($urandom); r_wdata[i] = $urandom;
          end
        end else if (pend[i]) begin
          if ($urandom_range(19, 0) == 0) pend[i] = 0;
        end else if ($urandom_range(9, 0) < 3) begin
          pend[i] = 1;
          we_v[i] = 1'($urandom); r_addr[i] = AW'($urandom); r_wdata[i] = $urandom;
        end
        req_v[i] = pend[i];
      end
      cdc_ack   = ($urandom_range(99, 0) < ((c < 1500) ? 40 : 6));
      cdc_rdata = $urandom;
      #1;
      last_gnt = gnt;
    end
    tick();
    req_v = '0; cdc_ack = 1'b0;
    ticks(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_cdc_req_sched.md
Name: reg_cdc_req_sched

Overview:
- Single-clock scheduler in the source register domain. Shares one register-CDC request channel between NumReq software requesters.
- Grants requesters round-robin and holds command data stable until the CDC returns a one-cycle ack. Routes the ack and read data back to the granted requester.
- Enforces a timeout with error response, then drains the stale ack so the channel protocol is never violated.

Parameters:
- NumReq, 4, number of requesters (2..16).
- AddrWidth, 8, register address width.
- DataWidth, 32, data width.
- TimeoutCycles, 1024, cycles in StWait before error response; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NumReq  level request per requester
- we_i  in  NumReq  write enable per requester
- addr_i  in  NumReq*AddrWidth  packed addresses, requester i at [i*AddrWidth +: AddrWidth]
- wdata_i  in  NumReq*DataWidth  packed write data
- gnt_o  out  NumReq  one-hot one-cycle grant pulse
- rsp_valid_o  out  NumReq  one-hot one-cycle response pulse
- rsp_err_o  out  1  response error, qualified by any rsp_valid_o
- rsp_rdata_o  out  DataWidth  response read data, broadcast to all requesters
- cdc_req_o  out  1  level request to CDC channel
- cdc_we_o  out  1  held write enable
- cdc_addr_o  out  AddrWidth  held address
- cdc_wdata_o  out  DataWidth  held write data
- cdc_ack_i  in  1  one-cycle ack from CDC
- cdc_rdata_i  in  DataWidth  read data, valid with cdc_ack_i
- busy_o  out  1  state != StIdle
- spurious_ack_o  out  1  sticky; set by an ack while cdc_req_o=0

Behaviour:
- Reset (async, rst_ni=0):
  - State StIdle; round-robin pointer 0; timeout counter 0.
  - All outputs 0, including hold registers and spurious_ack_o.
  - Reset mid-transaction abandons it silently: no response is issued.
- States: StIdle, StWait, StDrain.
- StIdle:
  - If any req_i is set, grant the first set bit searching from the pointer upward, with wrap.
  - In the grant cycle T: gnt_o[i]=1 (combinational); we/addr/wdata[i] latched into hold registers; grant id stored; pointer <= (i+1) mod NumReq; next state StWait.
  - No req_i set: remain in StIdle, no outputs.
- StWait:
  - cdc_req_o=1 from T+1, with cdc_we/addr/wdata equal to the held values and stable until cdc_req_o falls.
  - Timeout counter increments each cycle in StWait.
  - cdc_ack_i=1 in cycle A: at A+1, cdc_req_o=0, rsp_valid_o[id]=1, rsp_err_o=0, rsp_rdata_o=cdc_rdata_i sampled at A (write acks return the sampled value unchanged); state StIdle.
  - Counter reaches TimeoutCycles-1 without ack: next cycle rsp_valid_o[id]=1, rsp_err_o=1, rsp_rdata_o=0; state StDrain; cdc_req_o stays 1.
  - Ack and timeout in the same cycle: ack wins, normal response.
- StDrain:
  - cdc_req_o held at 1 with the same command.
  - On cdc_ack_i: ack discarded, no response; cdc_req_o=0 next cycle; state StIdle. The counter does not run here.
- Turnaround and throughput:
  - A new grant is possible in the cycle the previous response pulses (A+1), including to a different requester.
  - Minimum: grant T, ack T+1, response T+2. Peak throughput is one transaction per 2 cycles.
- Requester rules:
  - req_i/we_i/addr_i/wdata_i must be stable until gnt_o.
  - req_i may be withdrawn before grant; the scheduler ignores it from then on.
  - req_i held after grant re-requests and is arbitrated normally.
  - Inputs are not sampled outside the grant cycle.
- Response outputs are zero in non-response cycles: rsp_rdata_o=0 and rsp_err_o=0.
- Spurious ack: cdc_ack_i while cdc_req_o=0 sets spurious_ack_o (sticky until reset) and is otherwise ignored.
- Counter width is clog2(TimeoutCycles+1); it is cleared on entry to StWait.

Test Plan:
- Single read from req 2, addr 0x14, ack 3 cycles after cdc_req_o rises with rdata 0xDEADBEEF -> gnt_o=4'b0100 at T; cdc_addr_o=0x14 held; rsp_valid_o[2] with rdata 0xDEADBEEF, err 0.
- All four req_i held, immediate acks -> grant order 0,1,2,3,0; one grant per 2 cycles; no requester granted twice before the others.
- TimeoutCycles=8, no ack -> error response (err=1, rdata=0) after 8 StWait cycles; cdc_req_o stays 1; ack at +5 yields no response, then StIdle and a new grant is accepted.
- Ack coincident with the final timeout cycle -> normal response, err=0, no StDrain.
- cdc_ack_i pulsed in StIdle -> spurious_ack_o=1 and stays 1; no rsp_valid_o; subsequent transactions unaffected.
- rst_ni asserted mid-StWait -> all outputs 0 immediately, pointer 0; after release, req 3 alone is granted normally.
